cic_interp_sdm: RTL and testbench

Transmit-side counterpart of the 1-bit decimation path. It accepts signed PCM samples at the low rate (one per R clocks) through a valid/ready handshake and interpolates them by R with a 3-stage CIC (comb at the low rate, zero-stuffing, integrators at the high rate). The result goes to a first-order sigma-delta modulator that emits one bit per clk. It feeds the 1-bit DAC / loopback pin that the decimator consumes.

---
 rtl/cic_pkg.sv | 27 ++
 rtl/sigma_delta_mod1.sv | 43 ++++
 rtl/cic_interp_sdm.sv | 113 +++++++++++
 tb/tb_cic_interp_sdm.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// cic_pkg
// Constants and helpers shared by the CIC interpolator / sigma-delta transmit
// path and the matching 1-bit decimator.
//   CIC_N        : number of comb / integrator stages
//   IN_W_DEF     : default PCM sample width
//   LOG2R_DEF    : default log2 of the rate-change ratio
//   acc_w()      : register width that keeps the CIC exact under modular wrap
//   sdm_offset() : offset that maps a signed sample onto offset binary
package cic_pkg;

  localparam int CIC_N     = 3;
  localparam int IN_W_DEF  = 16;
  localparam int LOG2R_DEF = 6;

  // The CIC DC gain is R^(N-1) = 2^(2*LOG2R) for N = 3, so this many bits
  // hold the full-scale steady state. Intermediate wrap cancels out.
  function automatic int acc_w(input int in_w, input int log2r);
    return in_w + 2 * log2r;
  endfunction

  function automatic int sdm_offset(input int in_w);
    return 1 << (in_w - 1);
  endfunction

  localparam int SDM_OFFSET_DEF = 1 << (IN_W_DEF - 1);

endpackage

// File: rtl/sigma_delta_mod1.sv
// sigma_delta_mod1
// First-order sigma-delta modulator. The signed input is shifted to offset
// binary and added to an IN_W-bit accumulator each clock; the carry out of
// that addition is the output bit, so the density of ones is u / 2^IN_W.
//   clk    : bit clock
//   rst_n  : asynchronous active-low reset
//   y      : signed sample (IN_W bits), may change every clock
//   out    : registered modulated bit
module sigma_delta_mod1
  import cic_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] y,
  output logic                   out
);

  localparam logic [IN_W-1:0] OFFSET = IN_W'(sdm_offset(IN_W));

  logic [IN_W-1:0] r_acc;
  logic            r_out;
  logic [IN_W-1:0] w_u;
  logic [IN_W:0]   w_sum;

  // -32768 maps to 0 and +32767 to 65535 for IN_W = 16.
  assign w_u   = $unsigned(y) + OFFSET;
  assign w_sum = {1'b0, r_acc} + {1'b0, w_u};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_out <= 1'b0;
    end else begin
      r_acc <= w_sum[IN_W-1:0];
      r_out <= w_sum[IN_W];
    end
  end

  assign out = r_out;

endmodule

// File: rtl/cic_interp_sdm.sv
// cic_interp_sdm
// Interpolate signed PCM by R = 2^LOG2R with a 3-stage CIC (combs at the low
// rate, zero-stuffing, integrators at the bit rate) and modulate the result
// to a 1-bit stream with a first-order sigma-delta.
//   clk       : bit clock, the only clock
//   rst_n     : asynchronous active-low reset
//   in_data   : signed sample, IN_W bits
//   in_valid  : in_data valid
//   in_ready  : slot cycle (ph == R-1); a transfer is in_valid && in_ready
//   out       : modulated bitstream, one bit per clk
//   underrun  : one-cycle pulse at ph == 0 after a slot with no valid data
module cic_interp_sdm
  import cic_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int LOG2R = LOG2R_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out,
  output logic                   underrun
);

  localparam int              ACC_W   = acc_w(IN_W, LOG2R);
  localparam logic [LOG2R-1:0] PH_LAST = '1;

  logic [LOG2R-1:0]              r_ph;
  logic signed [IN_W-1:0]        r_hold;
  logic                          r_underrun;
  logic signed [ACC_W-1:0]       r_d [CIC_N];
  logic signed [ACC_W-1:0]       r_cout;
  logic signed [ACC_W-1:0]       r_i [CIC_N];

  logic                          w_slot;
  logic                          w_xfer;
  logic signed [IN_W-1:0]        w_x_in;
  logic signed [ACC_W-1:0]       w_c [CIC_N+1];
  logic signed [ACC_W-1:0]       w_v;
  logic signed [IN_W-1:0]        w_y;
  logic                          w_unused_lsbs;

  // Phase counter is a clock enable, not a divided clock.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ph <= '0;
    else        r_ph <= r_ph + LOG2R'(1);
  end

  assign w_slot   = (r_ph == PH_LAST);
  assign in_ready = w_slot;
  assign w_xfer   = w_slot && in_valid;

  // Zero-order hold: an empty slot replays the previous sample.
  assign w_x_in = w_xfer ? in_data : r_hold;

  // Comb chain on the slot sample, sign-extended to the accumulator width.
  // NOTE: every always_comb output gets a value before any condition or loop,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    for (int k = 0; k <= CIC_N; k++) w_c[k] = '0;
    w_c[0] = {{(ACC_W-IN_W){w_x_in[IN_W-1]}}, w_x_in};
    for (int k = 0; k < CIC_N; k++) w_c[k+1] = w_c[k] - r_d[k];
  end

  // Zero-stuffing: the new comb output feeds the integrators for one cycle.
  assign w_v = (r_ph == '0) ? r_cout : '0;

  // NOTE: the delay and integrator arrays are a few flops, not RAM, and they
  // must start from zero for the step response to be right, so they are
  // cleared by reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_underrun <= 1'b0;
      r_cout     <= '0;
      for (int k = 0; k < CIC_N; k++) begin
        r_d[k] <= '0;
        r_i[k] <= '0;
      end
    end else begin
      r_underrun <= w_slot && !in_valid;
      if (w_xfer) r_hold <= in_data;
      if (w_slot) begin
        for (int k = 0; k < CIC_N; k++) r_d[k] <= w_c[k];
        r_cout <= w_c[CIC_N];
      end
      // Each integrator adds the previous stage's old value: one cycle of
      // latency per stage.
      r_i[0] <= r_i[0] + w_v;
      for (int k = 1; k < CIC_N; k++) r_i[k] <= r_i[k] + r_i[k-1];
    end
  end

  // Divide by the DC gain R^2; the top IN_W bits are exactly i3 >>> 2*LOG2R.
  assign w_y           = r_i[CIC_N-1][ACC_W-1 -: IN_W];
  assign w_unused_lsbs = ^r_i[CIC_N-1][2*LOG2R-1:0];

  sigma_delta_mod1 #(
    .IN_W (IN_W)
  ) u_sdm (
    .clk   (clk),
    .rst_n (rst_n),
    .y     (w_y),
    .out   (out)
  );

  assign underrun = r_underrun;

endmodule

// File: tb/tb_cic_interp_sdm.sv
// tb_cic_interp_sdm
// Directed bench for cic_interp_sdm. Inputs change and outputs are sampled on
// the falling clock edge; the DUT registers on the rising edge.
module tb_cic_interp_sdm;

  localparam int IN_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic signed [IN_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   out;
  logic                   underrun;

  int n_pass  = 0;
  int n_total = 0;

  cic_interp_sdm #(
    .IN_W  (16),
    .LOG2R (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Advance to the next slot cycle, bounded; a missing slot is a failed check.
  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!in_ready && k < 128) begin
      tick();
      k++;
    end
    check(tag, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int     first;
    int     xfers;
    int     unders;
    int     ones;
    int     errs;
    int     wsum;
    logic   prev;
    logic [7:0] pat;
    logic   bits [512];

    // ---------------- reset, valid held high ----------------
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = '0;
    repeat (3) tick();
    check("reset_out", 32'(out), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd0);
    check("reset_underrun", 32'(underrun), 32'd0);
    tick();
    check("reset_out_held", 32'(out), 32'd0);

    rst_n  = 1'b1;
    first  = -1;
    xfers  = 0;
    unders = 0;
    for (int c = 0; c < 640; c++) begin
      if (in_ready && first < 0) first = c;
      if (in_ready && in_valid) xfers++;
      if (underrun) unders++;
      tick();
    end
    check("first_ready", 32'(first), 32'd63);
    check("transfers_640", 32'(xfers), 32'd10);
    check("no_underrun_valid", 32'(unders), 32'd0);

    // ---------------- zero input: 0,1,0,1 ----------------
    ones = 0;
    errs = 0;
    prev = out;
    for (int c = 0; c < 1024; c++) begin
      tick();
      ones += int'(out);
      if (out == prev) errs++;
      prev = out;
    end
    check("zero_ones_1024", 32'(ones), 32'd512);
    check("zero_alternate", 32'(errs), 32'd0);

    // ---------------- one empty slot ----------------
    wait_ready("slot_for_underrun");
    in_valid = 1'b0;
    in_data  = 16'sh1234;
    tick();
    check("underrun_pulse", 32'(underrun), 32'd1);
    in_valid = 1'b1;
    in_data  = '0;
    tick();
    check("underrun_clear", 32'(underrun), 32'd0);

    // Valid and junk data outside the slot must be ignored.
    errs   = 0;
    unders = 0;
    prev   = out;
    for (int c = 0; c < 256; c++) begin
      in_valid = in_ready;
      in_data  = in_ready ? 16'sd0 : 16'sd32767;
      tick();
      if (underrun) unders++;
      if (out == prev) errs++;
      prev = out;
    end
    check("post_underrun_alternate", 32'(errs), 32'd0);
    check("no_extra_underrun", 32'(unders), 32'd0);
    in_valid = 1'b1;
    in_data  = '0;

    // ---------------- +16384: u = 49152, 3 ones per 4 ----------------
    in_data = 16'sd16384;
    repeat (256) tick();
    ones = 0;
    for (int c = 0; c < 512; c++) begin
      tick();
      bits[c] = out;
      ones += int'(out);
    end
    errs = 0;
    for (int c = 0; c + 3 < 512; c++) begin
      wsum = int'(bits[c]) + int'(bits[c+1]) + int'(bits[c+2]) + int'(bits[c+3]);
      if (wsum != 3) errs++;
    end
    check("q3_window4", 32'(errs), 32'd0);
    check("q3_ones_512", 32'(ones), 32'd384);

    // ---------------- -32768: all zeros ----------------
    in_data = -16'sd32768;
    repeat (256) tick();
    ones = 0;
    for (int c = 0; c < 1024; c++) begin
      tick();
      ones += int'(out);
    end
    check("neg_fs_zeros", 32'(ones), 32'd0);

    // ---------------- step to 8192 at a slot: 2560 ones / 4096 ----------------
    wait_ready("slot_for_step");
    in_data = 16'sd8192;
    repeat (256) tick();
    ones = 0;
    for (int c = 0; c < 4096; c++) begin
      tick();
      ones += int'(out);
    end
    check("step_ones_4096", 32'(ones), 32'd2560);

    // ---------------- asynchronous reset mid-stream ----------------
    repeat ($urandom_range(1, 100)) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd0);
    check("async_rst_underrun", 32'(underrun), 32'd0);
    tick();
    tick();
    in_data = '0;
    rst_n   = 1'b1;
    first   = -1;
    pat     = '0;
    for (int c = 0; c < 130; c++) begin
      if (in_ready && first < 0) first = c;
      if (c >= 1 && c <= 8) pat = {pat[6:0], out};
      tick();
    end
    check("rerst_first_ready", 32'(first), 32'd63);
    // Cleared integrators and accumulator give 0,1,0,1... from the first edge.
    check("rerst_out_pattern", 32'(pat), 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
